// File: rtl/logic_analyser_capture_if.sv
// Signal bundle between a logic_analyser_capture and its surroundings: probes,
// trigger setup, control strobes, status flags and the UART line.
interface logic_analyser_capture_if #(
   parameter int SW = 12
);
   logic [SW-1:0] io_probes;
   logic [SW-1:0] io_trig_mask;
   logic [SW-1:0] io_trig_value;
   logic          io_arm;
   logic          io_abort;
   logic          io_busy;
   logic          io_triggered;
   logic          io_done;
   logic          io_uart_tx;

   modport master (
      output io_probes, io_trig_mask, io_trig_value, io_arm, io_abort,
      input  io_busy, io_triggered, io_done, io_uart_tx
   );

   modport slave (
      input  io_probes, io_trig_mask, io_trig_value, io_arm, io_abort,
      output io_busy, io_triggered, io_done, io_uart_tx
   );
endinterface

// File: rtl/logic_analyser_capture.sv
// Trigger-and-capture logic analyser: DEPTH samples into a buffer, then dumped as 8N1 UART.
// Define LA_EDGE_TRIGGER_EN for an edge trigger (masked bits change into the value).
module logic_analyser_capture #(
   parameter int PROBE_WIDTH  = 4,
   parameter int NUM_PROBES   = 3,
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                     clk,
   input  logic                     reset,
   logic_analyser_capture_if.slave  la
);
   localparam int SW    = PROBE_WIDTH * NUM_PROBES;
   localparam int BYTES = (SW + 7) / 8;
   localparam int PADW  = BYTES * 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DUMP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   samp_q, samp_d;
   logic [BW-1:0]   bsel_q, bsel_d;
   logic [3:0]      bit_q, bit_d;
   logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
   logic            tx_q, tx_d;
   logic            done_q, done_d;
   logic            mem_we;
   logic            hit;
   logic [SW-1:0]   mem_q [DEPTH];
   logic [PADW-1:0] samp_pad;
   logic [7:0]      cur_byte;

`ifdef LA_EDGE_TRIGGER_EN
   logic [SW-1:0] prev_q;
   logic          prev_vld_q;

   // prev is only trusted once ARMED has loaded it at least once
   always_ff @(posedge clk) begin
      if (reset) prev_vld_q <= 1'b0;
      else       prev_vld_q <= (state_q == S_ARMED) && !la.io_abort;
   end

   always_ff @(posedge clk) begin
      prev_q <= la.io_probes;
   end

   assign hit = prev_vld_q
             && (|((la.io_probes ^ prev_q) & la.io_trig_mask))
             && ((la.io_probes & la.io_trig_mask) == (la.io_trig_value & la.io_trig_mask));
`else
   assign hit = ~|((la.io_probes ^ la.io_trig_value) & la.io_trig_mask);
`endif

   assign samp_pad = PADW'(mem_q[samp_q]);
   assign cur_byte = samp_pad[int'(bsel_q)*8 +: 8];

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      samp_d    = samp_q;
      bsel_d    = bsel_q;
      bit_d     = bit_q;
      clk_cnt_d = clk_cnt_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      mem_we    = 1'b0;
      if (la.io_abort) begin
         state_d   = S_IDLE;
         wr_ptr_d  = '0;
         samp_d    = '0;
         bsel_d    = '0;
         bit_d     = '0;
         clk_cnt_d = '0;
         tx_d      = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (la.io_arm) state_d = S_ARMED;
            end
            S_ARMED: begin
               if (hit) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  state_d  = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               // start bit is registered on the same edge that enters DUMP
               if (wr_ptr_q == AW'(DEPTH - 1)) begin
                  state_d   = S_DUMP;
                  samp_d    = '0;
                  bsel_d    = '0;
                  bit_d     = '0;
                  clk_cnt_d = '0;
                  tx_d      = 1'b0;
               end
            end
            S_DUMP: begin
               if (clk_cnt_q != CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt_d = clk_cnt_q + 1'b1;
               end else begin
                  clk_cnt_d = '0;
                  if (bit_q == 4'd9) begin
                     bit_d = '0;
                     if (samp_q == AW'(DEPTH - 1) && bsel_q == BW'(BYTES - 1)) begin
                        state_d = S_IDLE;
                        samp_d  = '0;
                        bsel_d  = '0;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                     end else begin
                        if (bsel_q == BW'(BYTES - 1)) begin
                           bsel_d = '0;
                           samp_d = samp_q + 1'b1;
                        end else begin
                           bsel_d = bsel_q + 1'b1;
                        end
                        tx_d = 1'b0;
                     end
                  end else begin
                     bit_d = bit_q + 4'd1;
                     tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         samp_q    <= '0;
         bsel_q    <= '0;
         bit_q     <= '0;
         clk_cnt_q <= '0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         samp_q    <= samp_d;
         bsel_q    <= bsel_d;
         bit_q     <= bit_d;
         clk_cnt_q <= clk_cnt_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= la.io_probes;
   end

   assign la.io_busy      = (state_q != S_IDLE);
   assign la.io_triggered = (state_q == S_CAPTURE) || (state_q == S_DUMP);
   assign la.io_done      = done_q;
   assign la.io_uart_tx   = tx_q;
endmodule

// File: tb/tb_logic_analyser_capture.sv
// Directed bench for logic_analyser_capture with DEPTH=4, CLKS_PER_BIT=4, 12-bit samples.
module tb_logic_analyser_capture;
   localparam int PW    = 4;
   localparam int NP    = 3;
   localparam int SW    = PW * NP;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;
   localparam int NB    = DEPTH * 2;

   logic clk = 1'b0;
   logic reset;
   int   errors_n = 0;
   int   checks_n = 0;

   logic_analyser_capture_if #(.SW(SW)) la ();

   logic_analyser_capture #(
      .PROBE_WIDTH(PW), .NUM_PROBES(NP), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk), .reset(reset), .la(la)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_n++;
      if (got !== exp) begin
         errors_n++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Arms with the current mask and feeds four samples; with mask 0 the first
   // sample is the hit and the last step lands in DUMP.
   task automatic arm_and_feed(input logic [SW-1:0] s0, s1, s2, s3, input bit arm_mid);
      la.io_arm = 1'b1; step(); la.io_arm = 1'b0;
      la.io_probes = s0; step();
      la.io_probes = s1; la.io_arm = arm_mid; step(); la.io_arm = 1'b0;
      la.io_probes = s2; step();
      la.io_probes = s3; step();
   endtask

   // Called on the first DUMP cycle; records the whole line and decodes it.
   task automatic expect_dump(input string tag, input logic [63:0] exp, input int arm_at,
                              input bit chk_first);
      logic [NB*40-1:0] tx_log;
      logic [63:0]      got;
      logic [39:0]      first;
      int               done_seen;
      int               frame_err;
      tx_log = '0; got = '0; first = '0; done_seen = 0; frame_err = 0;
      for (int i = 0; i < NB * 40; i++) begin
         tx_log[i] = la.io_uart_tx;
         if (la.io_done) done_seen++;
         la.io_arm = (i == arm_at);
         step();
      end
      la.io_arm = 1'b0;
      check_val({tag, " done pulse"}, la.io_done, 1);
      check_val({tag, " busy after"}, la.io_busy, 0);
      check_val({tag, " tx after"}, la.io_uart_tx, 1);
      check_val({tag, " early done"}, done_seen, 0);
      for (int k = 0; k < NB; k++) begin
         if (tx_log[k*40 + 2] !== 1'b0 || tx_log[k*40 + 38] !== 1'b1) frame_err++;
         for (int b = 0; b < 8; b++) got[k*8 + b] = tx_log[k*40 + (b+1)*4 + 2];
      end
      check_val({tag, " framing"}, frame_err, 0);
      check_val({tag, " bytes"}, got, exp);
      if (chk_first) begin
         for (int i = 0; i < 40; i++) first[i] = tx_log[i];
         check_val({tag, " frame0 bits"}, first, 40'hF0F0FFF000);
      end
      step();
      check_val({tag, " done width"}, la.io_done, 0);
   endtask

   initial begin
      int bad;
      reset = 1'b1;
      la.io_probes = '0; la.io_trig_mask = '0; la.io_trig_value = '0;
      la.io_arm = 1'b0; la.io_abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("rst tx", la.io_uart_tx, 1);
         check_val("rst busy", la.io_busy, 0);
         check_val("rst done", la.io_done, 0);
      end
      reset = 1'b0;
      step();
      check_val("post-rst tx", la.io_uart_tx, 1);
      check_val("post-rst busy", la.io_busy, 0);
      check_val("post-rst trig", la.io_triggered, 0);

`ifndef LA_EDGE_TRIGGER_EN
      // level trigger on 12'hA5C
      la.io_trig_mask = 12'hFFF; la.io_trig_value = 12'hA5C; la.io_probes = 12'h000;
      la.io_arm = 1'b1; step(); la.io_arm = 1'b0;
      check_val("armed busy", la.io_busy, 1);
      check_val("armed trig", la.io_triggered, 0);
      repeat (4) step();
      check_val("no hit on mismatch", la.io_triggered, 0);
      la.io_probes = 12'hA5C; step();
      check_val("trig after hit", la.io_triggered, 1);
      la.io_probes = 12'h001; step();
      la.io_probes = 12'h002; step();
      la.io_probes = 12'h003; step();
      check_val("dump start bit", la.io_uart_tx, 0);
      check_val("dump trig", la.io_triggered, 1);
      expect_dump("level", {16'h0003, 16'h0002, 16'h0001, 16'h0A5C}, -1, 1'b1);

      // mask 0 hits on the first ARMED cycle
      la.io_trig_mask = '0;
      la.io_arm = 1'b1; step(); la.io_arm = 1'b0;
      check_val("mask0 armed", la.io_triggered, 0);
      la.io_probes = 12'h123; step();
      check_val("mask0 trig", la.io_triggered, 1);
      la.io_probes = 12'h456; step();
      la.io_probes = 12'h789; step();
      la.io_probes = 12'hABC; step();
      expect_dump("mask0", {16'h0ABC, 16'h0789, 16'h0456, 16'h0123}, -1, 1'b0);

      // abort mid-frame, with a simultaneous arm that must be ignored
      arm_and_feed(12'h000, 12'h111, 12'h222, 12'h333, 1'b0);
      repeat (10) step();
      la.io_abort = 1'b1; la.io_arm = 1'b1; step();
      la.io_abort = 1'b0; la.io_arm = 1'b0;
      check_val("abort tx", la.io_uart_tx, 1);
      check_val("abort busy", la.io_busy, 0);
      check_val("abort trig", la.io_triggered, 0);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (!la.io_uart_tx || la.io_done || la.io_busy) bad++;
         step();
      end
      check_val("abort quiet", bad, 0);
      arm_and_feed(12'h0F0, 12'h0E1, 12'h0D2, 12'h0C3, 1'b0);
      expect_dump("rearm", {16'h00C3, 16'h00D2, 16'h00E1, 16'h00F0}, -1, 1'b0);

      // arm pulses during CAPTURE and DUMP are ignored
      arm_and_feed(12'h5A5, 12'hA5A, 12'hF00, 12'h00F, 1'b1);
      expect_dump("arm-ignored", {16'h000F, 16'h0F00, 16'h0A5A, 16'h05A5}, 100, 1'b0);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (la.io_busy || !la.io_uart_tx) bad++;
         step();
      end
      check_val("single dump", bad, 0);

      // reset in the middle of a dump
      arm_and_feed(12'h000, 12'h001, 12'h002, 12'h003, 1'b0);
      repeat (5) step();
      reset = 1'b1; step(); reset = 1'b0;
      check_val("mid rst tx", la.io_uart_tx, 1);
      check_val("mid rst busy", la.io_busy, 0);
      check_val("mid rst trig", la.io_triggered, 0);
      check_val("mid rst done", la.io_done, 0);
      step();
`else
      // edge trigger: steady match must not hit, 0->1 transition must
      la.io_trig_mask = 12'h001; la.io_trig_value = 12'h001; la.io_probes = 12'h001;
      la.io_arm = 1'b1; step(); la.io_arm = 1'b0;
      check_val("edge armed", la.io_busy, 1);
      repeat (3) step();
      check_val("edge steady", la.io_triggered, 0);
      la.io_probes = 12'h000; step();
      check_val("edge fall", la.io_triggered, 0);
      la.io_probes = 12'h001; step();
      check_val("edge rise", la.io_triggered, 1);
      la.io_probes = 12'h00A; step();
      la.io_probes = 12'h00B; step();
      la.io_probes = 12'h00C; step();
      check_val("edge start bit", la.io_uart_tx, 0);
      expect_dump("edge", {16'h000C, 16'h000B, 16'h000A, 16'h0001}, -1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
      $finish;
   end
endmodule
